prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 8 +
 rtl/prog_loader.sv | 91 +++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream handshake between a byte source and the loader
interface prog_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    modport master(output byte_in, byte_valid, input byte_ready);
    modport slave(input byte_in, byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: buffers a byte stream and writes PROG_LEN bytes into a CPU instruction port, one CPU clock setup plus one hold per byte; LOADER_CHECKSUM_EN enables the commit checksum
module prog_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int PROG_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_tick,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic [7:0]   cpu_fill,
    output logic         instr_we,
    output logic         busy,
    output logic         done,
    output logic [7:0]   wr_count,
    output logic [7:0]   checksum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0] LEN = 8'(PROG_LEN);
    typedef enum logic [2:0] {IDLE, FETCH, SETUP, HOLD, DONE} state_t;
    state_t state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic rdy_en, push, pop, go;
    assign go = start && (state == IDLE || state == DONE);
    assign pop = state == FETCH && occ != '0;
    assign bus.byte_ready = rdy_en && state != DONE && (occ != FULL || pop);
    assign push = bus.byte_valid && bus.byte_ready;
    // byte storage; contents need no reset since reset empties the pointers
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.byte_in;
    // FIFO pointers and occupancy; ready is held off until the first edge after reset
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    // load sequencer: write strobe changes only on CPU tick edges once a byte is set up
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cpu_fill <= 8'h00;
            instr_we <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            wr_count <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: if (go) begin
                    state <= FETCH;
                    busy <= 1'b1;
                    done <= 1'b0;
                    wr_count <= 8'h00;
                end
                FETCH: if (pop) begin
                    cpu_fill <= mem[rd_ptr];
                    instr_we <= 1'b1;
                    state <= SETUP;
                end
                SETUP: if (cpu_tick) begin
                    instr_we <= 1'b0;
                    wr_count <= wr_count == LEN ? wr_count : wr_count + 8'd1;
                    state <= HOLD;
                end
                HOLD: if (cpu_tick) begin
                    state <= wr_count == LEN ? DONE : FETCH;
                    busy <= wr_count != LEN;
                    done <= wr_count == LEN;
                end
                default: state <= IDLE;
            endcase
        end
`ifdef LOADER_CHECKSUM_EN
    // modulo-256 sum of committed bytes, restarted with each load
    always_ff @(posedge clk or negedge rst)
        if (!rst) checksum <= 8'h00;
        else if (go) checksum <= 8'h00;
        else if (state == SETUP && cpu_tick) checksum <= checksum + cpu_fill;
`else
    assign checksum = 8'h00;
`endif
endmodule
